bomberman_input_encoder: RTL and testbench
==========================================

BOMBERMAN_INPUT_ENCODER -- requirements
Module: bomberman_input_encoder

Interface
REQ-001 Parameter TICK_DIV, default 12500000: clocks per move tick (4 moves/s at 50 MHz).
REQ-002 Parameter BOMB_COOLDOWN, default 8: move ticks a player must wait after a bomb pulse before another is accepted.
REQ-003 clock  in  1  system clock; one clock domain, all state on posedge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  game-running qualifier; low suppresses all mov/bomb pulses.
REQ-006 p1_up, p1_down, p1_left, p1_right, p1_bomb_key  in  1 each  raw active-high player 1 keys, asynchronous to clock.
REQ-007 p2_up, p2_down, p2_left, p2_right, p2_bomb_key  in  1 each  raw active-high player 2 keys.
REQ-008 p1_xmov, p1_xdir, p1_ymov, p1_ydir, p1_bomb  out  1 each  player 1 move/bomb commands to the datapath.
REQ-009 p2_xmov, p2_xdir, p2_ymov, p2_ydir, p2_bomb  out  1 each  player 2 commands, same encoding.

Function
REQ-010 Each raw key SHALL pass a 2-flop synchronizer; all logic uses synchronized values only.
REQ-011 A shared tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick is high only in the cycle when count == TICK_DIV-1.
REQ-012 Direction encoding: xdir=1 means right (increasing X), ydir=1 means down (increasing Y); 0 means left/up.
REQ-013 Per player, on a tick cycle with enable high, the requested X axis is right XOR left and Y axis is down XOR up; left+right together (or up+down) yields no request on that axis.
REQ-014 At most one of xmov/ymov SHALL be high per player per pulse; if both axes are requested, the axis is chosen by a per-player alternation bit (0 = X, 1 = Y), toggled after each such dual-request tick.
REQ-015 If only one axis is requested, that axis moves and the alternation bit is unchanged.
REQ-016 The selected mov output SHALL be high for exactly the one cycle following the tick cycle; otherwise low.
REQ-017 xdir/ydir SHALL be registered, updated only together with their mov pulse, and hold their value between pulses.
REQ-018 Bomb: a rising edge of the synchronized bomb key with enable high and cooldown == 0 SHALL produce a one-cycle bomb pulse exactly 3 clock edges after the raw key is first sampled high.
REQ-019 On each bomb pulse, the cooldown counter SHALL load BOMB_COOLDOWN and decrement by 1 per tick, saturating at 0; edges during cooldown are discarded, not queued.
REQ-020 Holding the bomb key SHALL produce only one pulse; a release and re-press is required.
REQ-021 Players are fully independent; simultaneous events of both players SHALL both be serviced in the same cycle.
REQ-022 enable low SHALL not stop the tick counter or cooldown decrement.

Reset
REQ-023 reset SHALL asynchronously clear synchronizers, edge registers, tick counter, alternation bits, cooldowns, and all outputs to 0.
REQ-024 Deassertion mid-operation SHALL restart the tick phase from count 0; no pulse is emitted within the first TICK_DIV cycles for moves or the first 3 cycles for bombs.

Structure
REQ-025 Direction encoding constants and default TICK_DIV/BOMB_COOLDOWN SHALL live in the shared bomberman package.
REQ-026 Per-player logic (sync, alternation, dir regs, bomb edge/cooldown) SHALL be one sub-module, bomberman_player_encoder, instantiated twice, fed the shared tick.

Verification (TICK_DIV=4, BOMB_COOLDOWN=2)
REQ-027 Hold p1_right for 12 cycles after reset -> p1_xmov pulses 3 times, 4 cycles apart, p1_xdir=1, p1_ymov never high.
REQ-028 Hold p1_up and p1_left together -> pulses alternate xmov(xdir=0), ymov(ydir=0), xmov...; never both in one cycle.
REQ-029 Hold p2_left+p2_right -> no p2_xmov; p2_xdir keeps previous value.
REQ-030 Press p1_bomb_key, release, re-press within 2 ticks -> one p1_bomb pulse 3 cycles after first press, second press ignored; press after 2 ticks -> second pulse.
REQ-031 enable=0 while all keys held -> all mov/bomb outputs stay 0; tick counter keeps running.
REQ-032 Assert reset mid-hold with p2_down held -> outputs 0 immediately; after release, first p2_ymov(ydir=1) exactly in cycle TICK_DIV after reset deasserts.

Source files
------------

// File: rtl/bomberman_input_encoder_pkg.sv
// Shared bomberman definitions: default tick/cooldown values, direction
// encoding, and the packed key/command bundles used between the top and the
// per-player encoder.
package bomberman_input_encoder_pkg;

  // 4 move ticks per second at a 50 MHz system clock.
  localparam int unsigned TICK_DIV_DEFAULT      = 12500000;
  // Move ticks between accepted bomb pulses.
  localparam int unsigned BOMB_COOLDOWN_DEFAULT = 8;

  // Direction bit values as seen by the datapath.
  localparam logic DIR_RIGHT = 1'b1;  // increasing X
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;  // increasing Y
  localparam logic DIR_UP    = 1'b0;

  // Which axis wins the next dual-axis request.
  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_e;

  // Raw or synchronized key set of one player.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic bomb;
  } keys_t;

  // Command bundle of one player towards the datapath.
  typedef struct packed {
    logic xmov;
    logic xdir;
    logic ymov;
    logic ydir;
    logic bomb;
  } cmd_t;

endpackage

// File: rtl/bomberman_player_encoder.sv
// Per-player key encoder: synchronizes raw keys, turns held direction keys
// into one-cycle move pulses on each shared tick (alternating axes when both
// are requested), and turns bomb-key presses into rate-limited bomb pulses.
// Ports: clock, reset (async, active-high), enable, tick (shared move tick),
//        keys (raw, asynchronous), cmd (registered move/dir/bomb commands).
module bomberman_player_encoder
  import bomberman_input_encoder_pkg::*;
#(
  parameter int unsigned BOMB_COOLDOWN = BOMB_COOLDOWN_DEFAULT
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  enable,
  input  logic  tick,
  input  keys_t keys,
  output cmd_t  cmd
);

  localparam int CDW = (BOMB_COOLDOWN < 1) ? 1 : $clog2(BOMB_COOLDOWN + 1);

  keys_t          sync_a;
  keys_t          sync_b;
  axis_e          alt;
  logic           bomb_prev;
  logic           bomb_rise;
  logic [CDW-1:0] cooldown;

  logic x_req;
  logic y_req;
  logic move_now;
  logic take_x;
  logic take_y;
  logic alt_flip;
  logic fire;

  // Two-flop synchronizer on every raw key.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= keys;
      sync_b <= sync_a;
    end
  end

  // Opposite keys on one axis cancel out.
  always_comb begin
    x_req    = sync_b.right ^ sync_b.left;
    y_req    = sync_b.down ^ sync_b.up;
    move_now = tick & enable;
    take_x   = move_now & x_req & (~y_req | (alt == AXIS_X));
    take_y   = move_now & y_req & (~x_req | (alt == AXIS_Y));
    alt_flip = move_now & x_req & y_req;
    fire     = bomb_rise & enable & (cooldown == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd       <= '0;
      alt       <= AXIS_X;
      bomb_prev <= 1'b0;
      bomb_rise <= 1'b0;
      cooldown  <= '0;
    end else begin
      // Move pulses: high for the single cycle after the tick cycle.
      cmd.xmov <= take_x;
      cmd.ymov <= take_y;
      // Direction bits only change alongside their own mov pulse.
      if (take_x) cmd.xdir <= sync_b.right ? DIR_RIGHT : DIR_LEFT;
      if (take_y) cmd.ydir <= sync_b.down ? DIR_DOWN : DIR_UP;
      if (alt_flip) alt <= (alt == AXIS_X) ? AXIS_Y : AXIS_X;

      // Bomb edge is registered once more so the pulse lands three edges
      // after the first edge that samples the raw key high.
      bomb_prev <= sync_b.bomb;
      bomb_rise <= sync_b.bomb & ~bomb_prev;
      cmd.bomb  <= fire;

      // A fresh pulse reloads the cooldown; ticks keep draining it even
      // while the game is not enabled.
      if (fire) begin
        cooldown <= CDW'(BOMB_COOLDOWN);
      end else if (tick && (cooldown != '0)) begin
        cooldown <= cooldown - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bomberman_input_encoder.sv
// Two-player input encoder: one free-running move-tick divider shared by two
// independent per-player encoders that produce move/dir/bomb commands.
// Ports: clock, reset (async, active-high), enable, p1_*/p2_* raw keys in,
//        p1_*/p2_* xmov/xdir/ymov/ydir/bomb commands out.
module bomberman_input_encoder
  import bomberman_input_encoder_pkg::*;
#(
  parameter int unsigned TICK_DIV      = TICK_DIV_DEFAULT,
  parameter int unsigned BOMB_COOLDOWN = BOMB_COOLDOWN_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic p1_up,
  input  logic p1_down,
  input  logic p1_left,
  input  logic p1_right,
  input  logic p1_bomb_key,
  input  logic p2_up,
  input  logic p2_down,
  input  logic p2_left,
  input  logic p2_right,
  input  logic p2_bomb_key,
  output logic p1_xmov,
  output logic p1_xdir,
  output logic p1_ymov,
  output logic p1_ydir,
  output logic p1_bomb,
  output logic p2_xmov,
  output logic p2_xdir,
  output logic p2_ymov,
  output logic p2_ydir,
  output logic p2_bomb
);

  localparam int CW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);

  logic [CW-1:0] count;
  logic          tick;
  keys_t         p1_keys;
  keys_t         p2_keys;
  cmd_t          p1_cmd;
  cmd_t          p2_cmd;

  // Tick divider keeps running regardless of enable so move phase and
  // cooldowns stay aligned to reset.
  assign tick = (count == CW'(TICK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign p1_keys = {p1_up, p1_down, p1_left, p1_right, p1_bomb_key};
  assign p2_keys = {p2_up, p2_down, p2_left, p2_right, p2_bomb_key};

  bomberman_player_encoder #(
    .BOMB_COOLDOWN(BOMB_COOLDOWN)
  ) u_p1 (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .tick  (tick),
    .keys  (p1_keys),
    .cmd   (p1_cmd)
  );

  bomberman_player_encoder #(
    .BOMB_COOLDOWN(BOMB_COOLDOWN)
  ) u_p2 (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .tick  (tick),
    .keys  (p2_keys),
    .cmd   (p2_cmd)
  );

  assign {p1_xmov, p1_xdir, p1_ymov, p1_ydir, p1_bomb} = p1_cmd;
  assign {p2_xmov, p2_xdir, p2_ymov, p2_ydir, p2_bomb} = p2_cmd;

endmodule

// File: tb/tb_bomberman_input_encoder.sv
// Testbench for bomberman_input_encoder with TICK_DIV=4, BOMB_COOLDOWN=2.
// Expected pulses (cycle, mov/bomb, direction) are queued per player when
// keys are driven and matched against every pulse the DUT emits.
module tb_bomberman_input_encoder;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic p1_up, p1_down, p1_left, p1_right, p1_bomb_key;
  logic p2_up, p2_down, p2_left, p2_right, p2_bomb_key;
  logic p1_xmov, p1_xdir, p1_ymov, p1_ydir, p1_bomb;
  logic p2_xmov, p2_xdir, p2_ymov, p2_ydir, p2_bomb;
  logic [9:0] outs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic running = 1'b0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] o1;
  logic [31:0] o2;

  always #5 clock = ~clock;

  assign outs = {p1_xmov, p1_xdir, p1_ymov, p1_ydir, p1_bomb,
                 p2_xmov, p2_xdir, p2_ymov, p2_ydir, p2_bomb};

  bomberman_input_encoder #(
    .TICK_DIV     (4),
    .BOMB_COOLDOWN(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p1_left    (p1_left),
    .p1_right   (p1_right),
    .p1_bomb_key(p1_bomb_key),
    .p2_up      (p2_up),
    .p2_down    (p2_down),
    .p2_left    (p2_left),
    .p2_right   (p2_right),
    .p2_bomb_key(p2_bomb_key),
    .p1_xmov    (p1_xmov),
    .p1_xdir    (p1_xdir),
    .p1_ymov    (p1_ymov),
    .p1_ydir    (p1_ydir),
    .p1_bomb    (p1_bomb),
    .p2_xmov    (p2_xmov),
    .p2_xdir    (p2_xdir),
    .p2_ymov    (p2_ymov),
    .p2_ydir    (p2_ydir),
    .p2_bomb    (p2_bomb)
  );

  // Clock edges since reset was released: after edge k, cyc == k.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack_ev(input int c, input logic xm, input logic ym,
                                          input logic bm, input logic dir);
    logic [31:0] v;
    v = '0;
    v[31:16] = c[15:0];
    v[3:0]   = {xm, ym, bm, dir};
    return v;
  endfunction

  task automatic push_ev(input int pl, input int c, input logic xm, input logic ym,
                         input logic bm, input logic dir);
    if (pl == 1) q1.push_back(pack_ev(c, xm, ym, bm, dir));
    else         q2.push_back(pack_ev(c, xm, ym, bm, dir));
  endtask

  // Key driven after edge k reaches the synchronizer output after edge k+2;
  // ticks sit after edges 3,7,11..., pulses follow one edge later.
  function automatic int first_mov(input int k);
    return ((k + 6) / 4) * 4;
  endfunction

  task automatic run_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic drain(input string tag);
    check_eq({tag, "_p1_left"}, q1.size(), 0);
    check_eq({tag, "_p2_left"}, q2.size(), 0);
    q1.delete();
    q2.delete();
  endtask

  // Pulse monitor: every pulse must match the next queued expectation.
  always @(negedge clock) begin
    if (running && !reset) begin
      if (p1_xmov || p1_ymov || p1_bomb) begin
        o1 = pack_ev(cyc, p1_xmov, p1_ymov, p1_bomb, p1_xmov ? p1_xdir : (p1_ymov ? p1_ydir : 1'b0));
        if (q1.size() == 0) check_eq("p1_unexpected", o1, 32'd0);
        else                check_eq("p1_event", o1, q1.pop_front());
      end
      if (p2_xmov || p2_ymov || p2_bomb) begin
        o2 = pack_ev(cyc, p2_xmov, p2_ymov, p2_bomb, p2_xmov ? p2_xdir : (p2_ymov ? p2_ydir : 1'b0));
        if (q2.size() == 0) check_eq("p2_unexpected", o2, 32'd0);
        else                check_eq("p2_event", o2, q2.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int m;
    reset  = 1'b1;
    enable = 1'b1;
    {p1_up, p1_down, p1_left, p1_right, p1_bomb_key} = '0;
    {p2_up, p2_down, p2_left, p2_right, p2_bomb_key} = '0;
    repeat (3) @(negedge clock);
    check_eq("reset_outs", 32'(outs), 32'd0);
    reset   = 1'b0;
    running = 1'b1;

    // Single-axis hold: three right moves 4 cycles apart.
    k = cyc;
    p1_right = 1'b1;
    m = first_mov(k);
    for (int i = 0; i < 3; i++) push_ev(1, m + 4 * i, 1'b1, 1'b0, 1'b0, 1'b1);
    run_until(12);
    p1_right = 1'b0;
    run_until(20);
    drain("right_hold");
    check_eq("p1_xdir_hold", 32'(p1_xdir), 32'd1);

    // Up+left: axes alternate X, Y, X, Y, both with direction 0.
    k = cyc;
    p1_up = 1'b1;
    p1_left = 1'b1;
    m = first_mov(k);
    for (int i = 0; i < 4; i++) push_ev(1, m + 4 * i, (i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0);
    run_until(m + 12);
    p1_up = 1'b0;
    p1_left = 1'b0;
    run_until(cyc + 8);
    drain("alternate");

    // Both players move in the same cycle; then p2 left+right cancels.
    k = cyc;
    p1_down = 1'b1;
    p2_right = 1'b1;
    m = first_mov(k);
    push_ev(1, m, 1'b0, 1'b1, 1'b0, 1'b1);
    push_ev(2, m, 1'b1, 1'b0, 1'b0, 1'b1);
    run_until(m);
    p1_down = 1'b0;
    p2_left = 1'b1;
    run_until(m + 14);
    p2_left = 1'b0;
    p2_right = 1'b0;
    run_until(cyc + 8);
    drain("cancel");
    check_eq("p2_xdir_hold", 32'(p2_xdir), 32'd1);
    check_eq("p1_ydir_hold", 32'(p1_ydir), 32'd1);

    // Bombs: both players press together; p1 re-press during cooldown is
    // dropped, a long hold gives one pulse, later press fires again.
    run_until((cyc / 4 + 1) * 4 + 1);
    k = cyc;
    p1_bomb_key = 1'b1;
    p2_bomb_key = 1'b1;
    push_ev(1, k + 4, 1'b0, 1'b0, 1'b1, 1'b0);
    push_ev(2, k + 4, 1'b0, 1'b0, 1'b1, 1'b0);
    push_ev(1, k + 22, 1'b0, 1'b0, 1'b1, 1'b0);
    run_until(k + 2);
    p1_bomb_key = 1'b0;
    p2_bomb_key = 1'b0;
    run_until(k + 6);
    p1_bomb_key = 1'b1;
    run_until(k + 14);
    p1_bomb_key = 1'b0;
    run_until(k + 18);
    p1_bomb_key = 1'b1;
    run_until(k + 26);
    p1_bomb_key = 1'b0;
    run_until(cyc + 6);
    drain("bomb");

    // enable low with every key held: nothing may pulse.
    enable = 1'b0;
    run_until(cyc + 2);
    {p1_up, p1_down, p1_left, p1_right, p1_bomb_key} = '1;
    {p2_up, p2_down, p2_left, p2_right, p2_bomb_key} = '1;
    run_until(cyc + 20);
    {p1_up, p1_down, p1_left, p1_right, p1_bomb_key} = '0;
    {p2_up, p2_down, p2_left, p2_right, p2_bomb_key} = '0;
    run_until(cyc + 6);
    enable = 1'b1;
    run_until(cyc + 2);
    drain("disabled");

    // Tick phase kept running while disabled: next move still on cyc%4==0.
    k = cyc;
    p1_left = 1'b1;
    p2_bomb_key = 1'b1;
    m = first_mov(k);
    push_ev(1, m, 1'b1, 1'b0, 1'b0, 1'b0);
    push_ev(2, k + 4, 1'b0, 1'b0, 1'b1, 1'b0);
    run_until(m);
    p1_left = 1'b0;
    p2_bomb_key = 1'b0;
    run_until(cyc + 8);
    drain("reenabled");

    // Reset in the middle of a p2_down hold.
    k = cyc;
    p2_down = 1'b1;
    m = first_mov(k);
    push_ev(2, m, 1'b0, 1'b1, 1'b0, 1'b1);
    push_ev(2, m + 4, 1'b0, 1'b1, 1'b0, 1'b1);
    run_until(m + 6);
    check_eq("p2_ydir_pre_reset", 32'(p2_ydir), 32'd1);
    reset = 1'b1;
    p1_bomb_key = 1'b1;
    #1;
    check_eq("reset_async_outs", 32'(outs), 32'd0);
    drain("pre_reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    push_ev(2, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    push_ev(1, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    run_until(4);
    p2_down = 1'b0;
    p1_bomb_key = 1'b0;
    run_until(12);
    drain("post_reset");
    check_eq("p2_ydir_post_reset", 32'(p2_ydir), 32'd1);

    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
